riscv32ima_prefetch: RTL
========================

# riscv32ima_prefetch

Parametrised instruction prefetch unit for the riscv32ima core; successor to the single-line fetch stage. It sits between the instruction memory port and the decode stage. It issues line-aligned reads ahead of demand and unpacks each LINE_WIDTH line into INSN_WIDTH instructions, buffering them in a DEPTH-entry queue. It presents one instruction per valid/ready handshake. A write-back redirect flushes the queue and any in-flight read, then restarts at a word-granular target.

## Interface
- ADDR_WIDTH, 32, byte-address width.
- LINE_WIDTH, 64, memory read width; power of two, ≥ INSN_WIDTH.
- INSN_WIDTH, 32, instruction width.
- DEPTH, 4, queue entries (instructions); power of two, ≥ 2·WORDS where WORDS = LINE_WIDTH/INSN_WIDTH.
- RESET_PC, 32'h1000_0000, fetch address after reset.
- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset, asynchronous and active-high.
- fetch_valid  out  1  head instruction valid.
- fetch_ready  in  1  decode accepts head.
- fetch_address  out  ADDR_WIDTH  byte address of head instruction.
- fetch_data  out  INSN_WIDTH  head instruction.
- wback_pc_wen  in  1  redirect strobe.
- wback_pc  in  ADDR_WIDTH  redirect target; bits [1:0] ignored.
- i_ncs  out  1  active-low read request.
- i_nwe  out  1  tied 1.
- i_addr  out  ADDR_WIDTH  line-aligned request address.
- i_wdata, i_wmask  out  LINE_WIDTH  tied 0.
- i_rdata  in  LINE_WIDTH  read data, valid the cycle after acceptance.
- i_stall  in  1  memory cannot accept this cycle.

## Operation
- State: fetch PC `pc`, in-flight flag `inf` + `inf_addr` (unaligned start address), queue (addr, insn) with rd/wr pointers and count of width $clog2(DEPTH)+1.
- Request: i_ncs = 0 when !rst, !wback_pc_wen, and count + (inf ? WORDS : 0) + WORDS ≤ DEPTH. i_addr = pc with low $clog2(LINE_WIDTH/8) bits cleared.
- Acceptance: edge with !i_ncs && !i_stall. Set inf=1, inf_addr=pc, pc ← aligned(pc) + LINE_WIDTH/8 modulo 2^ADDR_WIDTH (wraps to 0). Otherwise inf ← 0.
- Response: on the edge after acceptance, if inf, push words k = offset(inf_addr) … WORDS−1 of i_rdata. Word k = i_rdata[k·INSN_WIDTH +: INSN_WIDTH], address aligned(inf_addr)+4k. The push is multi-write, in order, in one cycle.
- Pop: fetch_valid = count≠0. Head is removed on an edge with fetch_valid && fetch_ready. Push and pop in the same cycle are both honoured.
- Redirect (wback_pc_wen=1), priority over everything: count ← 0, inf ← 0 (response due next edge discarded), pc ← {wback_pc[ADDR_WIDTH-1:2],2'b00}. No request is issued that cycle. Any handshake in the same cycle is void.
- Words below the target offset in the first line after a redirect are never queued.
- Full: the credit rule guarantees no overflow. A push never overflows and is never dropped.

## Timing
- Reset values: fetch_valid 0, fetch_address 0, fetch_data 0, i_ncs 1, i_addr aligned(RESET_PC), pc RESET_PC, count 0, inf 0.
- Latency: request accepted at edge N, data sampled at edge N+1, fetch_valid high in cycle N+1→N+2. Total 2 edges from acceptance to first visible instruction.
- Redirect at edge R: fetch_valid low after R; first request at the cycle after R; earliest new instruction visible after R+2.
- Steady state: one line per cycle while credit allows, sustaining ≥1 instruction/cycle to decode.
- i_stall only blocks acceptance. Held i_ncs=0 with i_stall=1 keeps i_addr stable.
- Reset asserted mid-operation clears all state immediately. A response arriving after deassertion is discarded because inf=0.

## Structure
- Shared package riscv32ima_pkg: opcode constants, RESET_PC default, derived WORDS/LINE_BYTES localparams, and the queue entry struct (addr, insn).
- Sub-module riscv32ima_ibuf: DEPTH-entry queue with WORDS write ports, one read port, and flush.
- The parent holds pc, credit logic, inf tracking and unpack.

## Test plan
- Reset then free-run, fetch_ready=1, i_stall=0: i_addr 0x1000_0000, 0x1000_0008, …; fetch_address 0x1000_0000, 0x1000_0004, … contiguous with matching words.
- fetch_ready=0 for 10 cycles: exactly DEPTH=4 entries queued, i_ncs stays 1 once credit is exhausted, no word lost or duplicated when ready returns.
- Redirect to 0x2000_0004 while a read is in flight: the stale response is dropped and the first fetched item is 0x2000_0004 (word 1 of line 0x2000_0000); word 0 is never presented.
- i_stall=1 for 3 cycles at 0x1000_0010: i_addr held at 0x1000_0010; resumes in order with no gap or repeat.
- Wrap: redirect to 0xFFFF_FFF8, run: addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- Async rst pulse mid-burst with a full queue: fetch_valid 0 and i_ncs 1 immediately; restart at 0x1000_0000.

Source files
------------

// File: rtl/riscv32ima_pkg.sv
// Shared definitions for the riscv32ima core: opcodes, default fetch geometry
// and the prefetch queue entry layout.
package riscv32ima_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT   = 32'h1000_0000;
    localparam int          ADDR_WIDTH_DEFAULT = 32;
    localparam int          LINE_WIDTH_DEFAULT = 64;
    localparam int          INSN_WIDTH_DEFAULT = 32;
    localparam int          DEPTH_DEFAULT      = 4;
    localparam int          DEFAULT_WORDS      = LINE_WIDTH_DEFAULT / INSN_WIDTH_DEFAULT;
    localparam int          DEFAULT_LINE_BYTES = LINE_WIDTH_DEFAULT / 8;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_AMO    = 7'b0101111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // Entry layout for the default 32-bit configuration; the prefetch queue
    // packs {addr, insn} in this order at any width.
    typedef struct packed {
        logic [ADDR_WIDTH_DEFAULT-1:0] addr;
        logic [INSN_WIDTH_DEFAULT-1:0] insn;
    } fetch_entry_t;

    function automatic int words_per_line(input int line_w, input int insn_w);
        return line_w / insn_w;
    endfunction

endpackage

// File: rtl/riscv32ima_ibuf.sv
// Instruction queue: WORDS in-order write ports, one read port, single-cycle flush.
module riscv32ima_ibuf
    import riscv32ima_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int WORDS = DEFAULT_WORDS
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush_i,
    input  logic [WORDS-1:0]             push_en_i,
    input  logic [WORDS-1:0][WIDTH-1:0]  push_data_i,
    input  logic                         pop_i,
    output logic                         valid_o,
    output logic [WIDTH-1:0]             head_o,
    output logic [$clog2(DEPTH):0]       count_o
);

    localparam int PW = $clog2(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
    logic [PW-1:0]               rd_q, rd_d, wr_q, wr_d;
    logic [PW:0]                 count_q, count_d;

    // Enabled ports are packed into consecutive slots so a partial line
    // lands without gaps; the producer's credit check keeps this from overflowing.
    always_comb begin
        mem_d   = mem_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        count_d = count_q;
        if (flush_i) begin
            rd_d    = '0;
            wr_d    = '0;
            count_d = '0;
        end else begin
            for (int k = 0; k < WORDS; k++) begin
                if (push_en_i[k]) begin
                    mem_d[wr_d] = push_data_i[k];
                    wr_d        = wr_d + 1'b1;
                    count_d     = count_d + 1'b1;
                end
            end
            if (pop_i && count_q != '0) begin
                rd_d    = rd_q + 1'b1;
                count_d = count_d - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q   <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            count_q <= count_d;
        end
    end

    assign valid_o = (count_q != '0);
    assign head_o  = mem_q[rd_q];
    assign count_o = count_q;

endmodule

// File: rtl/riscv32ima_prefetch.sv
// Instruction prefetch: issues line reads ahead of decode, unpacks them into
// a queue and hands out one instruction per handshake; redirects flush everything.
module riscv32ima_prefetch
    import riscv32ima_pkg::*;
#(
    parameter int                    ADDR_WIDTH = ADDR_WIDTH_DEFAULT,
    parameter int                    LINE_WIDTH = LINE_WIDTH_DEFAULT,
    parameter int                    INSN_WIDTH = INSN_WIDTH_DEFAULT,
    parameter int                    DEPTH      = DEPTH_DEFAULT,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(RESET_PC_DEFAULT)
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  fetch_valid,
    input  logic                  fetch_ready,
    output logic [ADDR_WIDTH-1:0] fetch_address,
    output logic [INSN_WIDTH-1:0] fetch_data,
    input  logic                  wback_pc_wen,
    input  logic [ADDR_WIDTH-1:0] wback_pc,
    output logic                  i_ncs,
    output logic                  i_nwe,
    output logic [ADDR_WIDTH-1:0] i_addr,
    output logic [LINE_WIDTH-1:0] i_wdata,
    output logic [LINE_WIDTH-1:0] i_wmask,
    input  logic [LINE_WIDTH-1:0] i_rdata,
    input  logic                  i_stall
);

    localparam int WORDS      = words_per_line(LINE_WIDTH, INSN_WIDTH);
    localparam int LINE_BYTES = LINE_WIDTH / 8;
    localparam int INSN_BYTES = INSN_WIDTH / 8;
    localparam int OFF_BITS   = $clog2(LINE_BYTES);
    localparam int CW         = $clog2(DEPTH) + 1;
    localparam int DW         = CW + 2;
    localparam int ENTRY_W    = ADDR_WIDTH + INSN_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ADDR_WIDTH'(LINE_BYTES - 1);
    localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ADDR_WIDTH'(3);

    logic [ADDR_WIDTH-1:0]             pc_q, pc_d;
    logic [ADDR_WIDTH-1:0]             inf_addr_q, inf_addr_d;
    logic                              inf_q, inf_d;
    logic [CW-1:0]                     count;
    logic [DW-1:0]                     demand;
    logic                              req, accept, pop, buf_valid;
    logic [ADDR_WIDTH-1:0]             line_base;
    logic [WORDS-1:0]                  push_en;
    logic [WORDS-1:0][ENTRY_W-1:0]     push_data;
    logic [ENTRY_W-1:0]                head;

    // Words already queued plus a line still in flight plus the line we want
    // to request must fit, so a response can always be absorbed whole.
    always_comb begin
        demand = DW'(count) + DW'(WORDS);
        if (inf_q) begin
            demand = demand + DW'(WORDS);
        end
    end

    assign req    = !rst && !wback_pc_wen && (demand <= DW'(DEPTH));
    assign accept = req && !i_stall;
    assign pop    = buf_valid && fetch_ready && !wback_pc_wen;

    always_comb begin
        pc_d       = pc_q;
        inf_d      = 1'b0;
        inf_addr_d = inf_addr_q;
        if (wback_pc_wen) begin
            pc_d = wback_pc & ~WORD_MASK;
        end else if (accept) begin
            inf_d      = 1'b1;
            inf_addr_d = pc_q;
            pc_d       = (pc_q & ~LINE_MASK) + ADDR_WIDTH'(LINE_BYTES);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            inf_q      <= 1'b0;
            inf_addr_q <= '0;
        end else begin
            pc_q       <= pc_d;
            inf_q      <= inf_d;
            inf_addr_q <= inf_addr_d;
        end
    end

    // Words ahead of the start offset in the returned line are skipped.
    always_comb begin
        line_base = inf_addr_q & ~LINE_MASK;
        push_en   = '0;
        push_data = '0;
        for (int k = 0; k < WORDS; k++) begin
            push_en[k]   = inf_q && (inf_addr_q[OFF_BITS-1:0] <= OFF_BITS'(k * INSN_BYTES));
            push_data[k] = {line_base + ADDR_WIDTH'(k * INSN_BYTES),
                            i_rdata[k*INSN_WIDTH +: INSN_WIDTH]};
        end
    end

    riscv32ima_ibuf #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH),
        .WORDS (WORDS)
    ) u_ibuf (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (wback_pc_wen),
        .push_en_i   (push_en),
        .push_data_i (push_data),
        .pop_i       (pop),
        .valid_o     (buf_valid),
        .head_o      (head),
        .count_o     (count)
    );

    assign fetch_valid   = buf_valid;
    assign fetch_address = head[ENTRY_W-1:INSN_WIDTH];
    assign fetch_data    = head[INSN_WIDTH-1:0];

    assign i_ncs   = !req;
    assign i_nwe   = 1'b1;
    assign i_addr  = pc_q & ~LINE_MASK;
    assign i_wdata = '0;
    assign i_wmask = '0;

endmodule
